pixel_fetch_engine: RTL and testbench

Per-frame pixel fetcher between the stage modules and sdram_buffer. On each new_frame it sweeps the write raster and presents DrawX_write/DrawY_write to the stage modules. It samples their OR-combined SDRAM Address, issues pipelined Avalon-style reads to the SDRAM controller, and pushes the returned words into sdram_buffer. Back-pressure comes from buffer_full and from an outstanding-read limit.

---
 rtl/pixel_fetch_pkg.sv | 10 +
 rtl/fetch_credit_counter.sv | 37 +++
 rtl/sync.sv | 26 ++
 rtl/pixel_fetch_engine.sv | 173 +++++++++++++++++
 tb/tb_pixel_fetch_engine.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_fetch_pkg.sv
// Shared types and widths for the pixel fetch engine.
package pixel_fetch_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ISSUE, DRAIN} state_t;

   localparam int ADDR_W  = 25;
   localparam int DATA_W  = 32;
   localparam int COORD_W = 10;

endpackage

// File: rtl/fetch_credit_counter.sv
// Outstanding-read counter: increments on issue, decrements on return, saturates at zero.
module fetch_credit_counter #(
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             at_limit
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // A return with nothing outstanding is a protocol error and must not wrap.
   always_comb begin
      count_d = count_q;
      if (inc && !dec) begin
         count_d = count_q + 1'b1;
      end else if (!inc && dec) begin
         if (count_q != '0) count_d = count_q - 1'b1;
      end else if (inc && dec) begin
         if (count_q == '0) count_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count    = count_q;
   assign at_limit = (count_q >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync #(
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] meta_q;
   logic [N-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pixel_fetch_engine.sv
// Per-frame pixel fetcher: sweeps the write raster, issues pipelined SDRAM reads, pushes returns to sdram_buffer.
// Build option: PIXEL_FETCH_STATS_EN adds the stall_cycles output.
module pixel_fetch_engine
   import pixel_fetch_pkg::*;
#(
   parameter int H_RES           = 640,
   parameter int V_RES           = 480,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               new_frame,
   input  logic [ADDR_W-1:0]  Address,
   output logic [COORD_W-1:0] DrawX_write,
   output logic [COORD_W-1:0] DrawY_write,
   output logic [ADDR_W-1:0]  sdram_address,
   output logic               sdram_cs,
   output logic               sdram_read_n,
   input  logic               wait_request,
   input  logic               sdram_valid,
   input  logic [DATA_W-1:0]  sdram_data_in,
   input  logic               buffer_full,
   output logic               push,
   output logic [DATA_W-1:0]  buffer_data,
   output logic               busy,
   output logic               frame_done,
`ifdef PIXEL_FETCH_STATS_EN
   output logic               overrun,
   output logic [19:0]        stall_cycles
`else
   output logic               overrun
`endif
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               push_q, push_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               overrun_q, overrun_d;
   logic               nf_sync, nf_prev_q, start;
   logic               req, accept, at_limit;
   logic [CNT_W-1:0]   outstanding;

   sync #(.N(1)) u_new_frame_sync (
      .clk   (Clk),
      .rst_n (Reset_n),
      .d     (new_frame),
      .q     (nf_sync)
   );

   fetch_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
      .clk      (Clk),
      .rst_n    (Reset_n),
      .inc      (accept),
      .dec      (sdram_valid),
      .count    (outstanding),
      .at_limit (at_limit)
   );

   assign start = nf_sync & ~nf_prev_q;

   // Request is gated combinationally so buffer_full blocks an issue in the same cycle it rises.
   assign req    = (state_q == ISSUE) && !buffer_full && !at_limit;
   assign accept = req && !wait_request;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = addr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      overrun_d = overrun_q | (start && (state_q != IDLE));
      push_d    = sdram_valid;
      data_d    = sdram_valid ? sdram_data_in : data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = '0;
               y_d     = '0;
               busy_d  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            addr_d  = Address;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (accept) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
               state_d = ((x_q == X_LAST) && (y_q == Y_LAST)) ? DRAIN : SETUP;
            end
         end
         DRAIN: begin
            if ((outstanding == '0) && !sdram_valid) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         push_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         nf_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         push_q    <= push_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         nf_prev_q <= nf_sync;
      end
   end

   assign DrawX_write   = x_q;
   assign DrawY_write   = y_q;
   assign sdram_address = addr_q;
   assign sdram_cs      = req;
   assign sdram_read_n  = ~req;
   assign push          = push_q;
   assign buffer_data   = data_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign overrun       = overrun_q;

`ifdef PIXEL_FETCH_STATS_EN
   logic [19:0] stall_q, stall_d;

   // Any ISSUE cycle without an accepted read counts as a stall, whatever the cause.
   always_comb begin
      stall_d = stall_q;
      if ((state_q == IDLE) && start)        stall_d = '0;
      else if ((state_q == ISSUE) && !accept) stall_d = stall_q + 20'd1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) stall_q <= '0;
      else          stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_fetch_engine.sv
// Scoreboard bench for pixel_fetch_engine on a 4x2 raster with a delayed-return SDRAM model.
module tb_pixel_fetch_engine;

   localparam int H = 4;
   localparam int V = 2;
   localparam int MAXO = 4;
   localparam int NPIX = H * V;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        new_frame;
   logic [24:0] Address;
   logic [9:0]  DrawX_write, DrawY_write;
   logic [24:0] sdram_address;
   logic        sdram_cs, sdram_read_n;
   logic        wait_request;
   logic        sdram_valid = 1'b0;
   logic [31:0] sdram_data_in = '0;
   logic        buffer_full;
   logic        push;
   logic [31:0] buffer_data;
   logic        busy, frame_done, overrun;
`ifdef PIXEL_FETCH_STATS_EN
   logic [19:0] stall_cycles;
`endif

   typedef struct {
      int          due;
      logic [31:0] data;
   } ret_t;

   ret_t        pend[$];
   logic [24:0] exp_addr[$];
   logic [31:0] exp_data[$];

   int n_cmp = 0;
   int n_fail = 0;
   int fd_count = 0;
   int reads = 0;
   int out_bench = 0;
   int max_out = 0;
   int full_cs = 0;
   int push_full = 0;
   int delay = 2;
   int cyc = 0;
   int fd_base = 0;
   int rd_base = 0;

   always #5 Clk = ~Clk;

   // Stage-module model: address is a pure function of the write coordinate.
   assign Address = 25'(DrawY_write) * 25'd4 + 25'(DrawX_write);

   pixel_fetch_engine #(.H_RES(H), .V_RES(V), .MAX_OUTSTANDING(MAXO)) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .new_frame     (new_frame),
      .Address       (Address),
      .DrawX_write   (DrawX_write),
      .DrawY_write   (DrawY_write),
      .sdram_address (sdram_address),
      .sdram_cs      (sdram_cs),
      .sdram_read_n  (sdram_read_n),
      .wait_request  (wait_request),
      .sdram_valid   (sdram_valid),
      .sdram_data_in (sdram_data_in),
      .buffer_full   (buffer_full),
      .push          (push),
      .buffer_data   (buffer_data),
      .busy          (busy),
      .frame_done    (frame_done),
`ifdef PIXEL_FETCH_STATS_EN
      .overrun       (overrun),
      .stall_cycles  (stall_cycles)
`else
      .overrun       (overrun)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tmo(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
   endtask

   task automatic load_expect();
      for (int i = 0; i < NPIX; i++) begin
         exp_addr.push_back(25'(i));
         exp_data.push_back(32'hA500_0000 | 32'(i));
      end
   endtask

   task automatic start_frame();
      int edges;
      edges = 0;
      fd_base = fd_count;
      rd_base = reads;
      @(posedge Clk); #1;
      new_frame = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk); #1;
         if (busy) begin
            edges = i + 1;
            break;
         end
      end
      new_frame = 1'b0;
      if (edges == 0) tmo("start_busy");
      else check("start_latency", 64'(edges), 64'd3);
   endtask

   task automatic finish_frame(input string name, input logic exp_ovr);
      int ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge Clk); #1;
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) tmo({name, "_done"});
      @(negedge Clk); #1;
      check({name, "_frame_done_count"}, 64'(fd_count - fd_base), 64'd1);
      check({name, "_reads"}, 64'(reads - rd_base), 64'(NPIX));
      check({name, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
      check({name, "_data_left"}, 64'(exp_data.size()), 64'd0);
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_overrun"}, 64'(overrun), 64'(exp_ovr));
   endtask

   // SDRAM model plus monitor: sampled on the falling edge, acts on the next rising edge.
   initial begin
      logic        acc;
      logic [24:0] ea;
      logic [31:0] ed;
      forever begin
         @(negedge Clk);
         cyc++;
         if (!Reset_n) begin
            pend.delete();
            sdram_valid = 1'b0;
            out_bench   = 0;
         end else begin
            if (push) begin
               if (exp_data.size() == 0) begin
                  tmo("unexpected_push");
               end else begin
                  ed = exp_data.pop_front();
                  check("push_data", 64'(buffer_data), 64'(ed));
               end
               if (buffer_full) push_full++;
            end
            if (frame_done) fd_count++;
            if (buffer_full && sdram_cs) full_cs++;
            if (out_bench >= MAXO) check("limit_cs", 64'(sdram_cs), 64'd0);
            acc = sdram_cs && !sdram_read_n && !wait_request;
            if (acc) begin
               reads++;
               if (exp_addr.size() == 0) begin
                  tmo("unexpected_read");
               end else begin
                  ea = exp_addr.pop_front();
                  check("read_addr", 64'(sdram_address), 64'(ea));
               end
               pend.push_back('{due: cyc + delay, data: 32'hA500_0000 | 32'(sdram_address)});
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
               sdram_valid   = 1'b1;
               sdram_data_in = pend[0].data;
               void'(pend.pop_front());
            end else begin
               sdram_valid = 1'b0;
            end
            out_bench = out_bench + (acc ? 1 : 0) - (sdram_valid ? 1 : 0);
            if (out_bench > max_out) max_out = out_bench;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got busy=%0b required completion", busy);
      $fatal(1, "global timeout");
   end

   initial begin
      int found;
      Reset_n      = 1'b1;
      new_frame    = 1'b0;
      wait_request = 1'b0;
      buffer_full  = 1'b0;
      #2 Reset_n = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_drawx", 64'(DrawX_write), 64'd0);
      check("rst_drawy", 64'(DrawY_write), 64'd0);
      check("rst_cs", 64'(sdram_cs), 64'd0);
      check("rst_read_n", 64'(sdram_read_n), 64'd1);
      check("rst_addr", 64'(sdram_address), 64'd0);
      check("rst_push", 64'(push), 64'd0);
      check("rst_bdata", 64'(buffer_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(frame_done), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      Reset_n = 1'b1;
      repeat (2) @(posedge Clk);

      // Basic frame, 2-cycle return delay.
      delay = 2;
      load_expect();
      start_frame();
      finish_frame("basic", 1'b0);

      // Controller stall on the third read.
      load_expect();
      start_frame();
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge Clk); #1;
         if (sdram_cs && sdram_address == 25'd2) begin
            found = 1;
            break;
         end
      end
      if (found == 0) begin
         tmo("wait_find");
      end else begin
         wait_request = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("wait_addr_stable", 64'(sdram_address), 64'd2);
            check("wait_cs_held", 64'(sdram_cs), 64'd1);
            @(posedge Clk); #1;
         end
         wait_request = 1'b0;
      end
      finish_frame("wait", 1'b0);

      // buffer_full window from cycle 10 to cycle 30 of the frame.
      delay = 3;
      full_cs = 0;
      push_full = 0;
      load_expect();
      start_frame();
      for (int c = 1; c <= 30; c++) begin
         @(posedge Clk); #1;
         if (c == 10) buffer_full = 1'b1;
         if (c == 30) begin
            buffer_full = 1'b0;
            @(negedge Clk);
            check("full_resume_cs", 64'(sdram_cs), 64'd1);
         end
      end
      finish_frame("full", 1'b0);
      check("full_cs_count", 64'(full_cs), 64'd0);
      check("full_push_inflight", 64'(push_full > 0), 64'd1);

      // Long return delay exercises the outstanding limit.
      delay = 10;
      max_out = 0;
      load_expect();
      start_frame();
      finish_frame("limit", 1'b0);
      check("limit_max_outstanding", 64'(max_out), 64'(MAXO));

      // Second frame edge while busy.
      delay = 2;
      load_expect();
      start_frame();
      repeat (3) @(posedge Clk);
      #1 new_frame = 1'b1;
      repeat (4) @(posedge Clk);
      #1 new_frame = 1'b0;
      finish_frame("overrun", 1'b1);

      // Reset in the middle of an ISSUE cycle.
      load_expect();
      start_frame();
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge Clk); #1;
         if (sdram_cs && sdram_address == 25'd3) begin
            found = 1;
            break;
         end
      end
      if (found == 0) tmo("reset_find");
      Reset_n = 1'b0;
      #1;
      check("mid_rst_cs", 64'(sdram_cs), 64'd0);
      check("mid_rst_read_n", 64'(sdram_read_n), 64'd1);
      check("mid_rst_addr", 64'(sdram_address), 64'd0);
      check("mid_rst_drawx", 64'(DrawX_write), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_push", 64'(push), 64'd0);
      check("mid_rst_overrun", 64'(overrun), 64'd0);
      exp_addr.delete();
      exp_data.delete();
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;
      repeat (2) @(posedge Clk);
      load_expect();
      start_frame();
      check("post_rst_x", 64'(DrawX_write), 64'd0);
      check("post_rst_y", 64'(DrawY_write), 64'd0);
      finish_frame("post_reset", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
